// File: rtl/ram_frame_reader.sv
// rtl/ram_frame_reader.sv - drains one buffer per ready pulse into framed packets via a 2-entry FIFO
// Reads exactly DEPTH samples after each buffer-ready pulse, tags sop/eop,
// and reports frame completion, overrun and a running frame count.
module ram_frame_reader #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int FCNT_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  buffer_ready_i,
  input  logic [WIDTH-1:0]      rd_data_i,
  input  logic                  rd_valid_i,
  output logic                  rd_ready_o,
  output logic [WIDTH-1:0]      m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  m_sop_o,
  output logic                  m_eop_o,
  output logic                  frame_done_o,
  output logic                  overrun_o,
  output logic [FCNT_WIDTH-1:0] frame_count_o,
  output logic                  busy_o
);

  typedef enum logic {IDLE, DRAIN} state_t;

  localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH+1)'(DEPTH-1);

  logic [1:0]            rst_sync_q;
  logic                  rst_n;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   idx_q, idx_d;
  logic [1:0]            count_q;
  logic [WIDTH-1:0]      out_data_q, spare_data_q;
  logic                  out_sop_q, out_eop_q, spare_sop_q, spare_eop_q;
  logic                  done_q, overrun_q;
  logic [FCNT_WIDTH-1:0] fcnt_q;
  logic                  accept, pop, sop_in, eop_in, last, start;

  // Reset assertion is immediate; release is aligned to the clock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rst_sync_q <= 2'b00;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  assign rd_ready_o = (state_q == DRAIN) && (count_q != 2'd2);
  assign accept     = rd_valid_i && rd_ready_o;
  assign m_valid_o  = (count_q != 2'd0);
  assign pop        = m_valid_o && m_ready_i;
  assign sop_in     = (idx_q == '0);
  assign eop_in     = (idx_q == LAST_IDX);
  assign last       = accept && eop_in;
  assign start      = buffer_ready_i && enable_i;

  assign m_data_o      = out_data_q;
  assign m_sop_o       = out_sop_q && m_valid_o;
  assign m_eop_o       = out_eop_q && m_valid_o;
  assign frame_done_o  = done_q;
  assign overrun_o     = overrun_q;
  assign frame_count_o = fcnt_q;
  assign busy_o        = (state_q == DRAIN);

  // State and sample index registers.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state: a ready pulse restarts the index; the last accept ends the frame.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRAIN;
          idx_d   = '0;
        end
      end
      DRAIN: begin
        if (last) begin
          idx_d = '0;
          if (!start) state_d = IDLE;
        end else if (buffer_ready_i) begin
          idx_d = '0;
        end else if (accept) begin
          idx_d = idx_q + 1'b1;
        end
      end
    endcase
  end

  // Status pulses and the completed-frame counter.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      fcnt_q    <= '0;
    end else begin
      done_q    <= last;
      overrun_q <= (state_q == DRAIN) && buffer_ready_i && !last;
      if (last) fcnt_q <= fcnt_q + 1'b1;
    end
  end

  // Two-entry FIFO: out_* is the registered head, spare_* holds the second entry.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= 2'd0;
      out_data_q   <= '0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      spare_data_q <= '0;
      spare_sop_q  <= 1'b0;
      spare_eop_q  <= 1'b0;
    end else begin
      unique case ({accept, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            out_data_q <= rd_data_i;
            out_sop_q  <= sop_in;
            out_eop_q  <= eop_in;
          end else begin
            spare_data_q <= rd_data_i;
            spare_sop_q  <= sop_in;
            spare_eop_q  <= eop_in;
          end
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          if (count_q == 2'd2) begin
            out_data_q <= spare_data_q;
            out_sop_q  <= spare_sop_q;
            out_eop_q  <= spare_eop_q;
          end
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            out_data_q <= rd_data_i;
            out_sop_q  <= sop_in;
            out_eop_q  <= eop_in;
          end else begin
            out_data_q   <= spare_data_q;
            out_sop_q    <= spare_sop_q;
            out_eop_q    <= spare_eop_q;
            spare_data_q <= rd_data_i;
            spare_sop_q  <= sop_in;
            spare_eop_q  <= eop_in;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_frame_reader.sv
// tb/tb_ram_frame_reader.sv - scoreboard bench for ram_frame_reader
module tb_ram_frame_reader;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int FCW   = 16;

  logic             clk = 1'b0;
  logic             rst_ni = 1'b0;
  logic             enable_i = 1'b0;
  logic             buffer_ready_i = 1'b0;
  logic [WIDTH-1:0] rd_data_i = '0;
  logic             rd_valid_i = 1'b0;
  logic             rd_ready_o;
  logic [WIDTH-1:0] m_data_o;
  logic             m_valid_o;
  logic             m_ready_i = 1'b0;
  logic             m_sop_o, m_eop_o, frame_done_o, overrun_o, busy_o;
  logic [FCW-1:0]   frame_count_o;

  ram_frame_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FCNT_WIDTH(FCW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable_i), .buffer_ready_i(buffer_ready_i),
    .rd_data_i(rd_data_i), .rd_valid_i(rd_valid_i), .rd_ready_o(rd_ready_o),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .m_sop_o(m_sop_o), .m_eop_o(m_eop_o), .frame_done_o(frame_done_o),
    .overrun_o(overrun_o), .frame_count_o(frame_count_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             s;
    logic             e;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  // Reference model: frame position, FIFO occupancy and expected status.
  bit md_drain = 0;
  int md_idx = 0;
  int md_occ = 0;
  int md_fcnt = 0;
  bit md_done = 0;
  bit md_ovr = 0;
  logic [WIDTH-1:0] seq = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle, entered and left at posedge+1.
  task automatic cyc(input bit br, input bit en, input bit rv, input bit mr,
                     input logic [WIDTH-1:0] d);
    bit ready, acc, last, pop;
    chk("rd_ready", rd_ready_o, md_drain && md_occ < 2);
    chk("busy", busy_o, md_drain);
    chk("m_valid", m_valid_o, md_occ > 0);
    chk("frame_done", frame_done_o, md_done);
    chk("overrun", overrun_o, md_ovr);
    chk("frame_count", frame_count_o, md_fcnt);
    buffer_ready_i = br; enable_i = en; rd_valid_i = rv; m_ready_i = mr; rd_data_i = d;
    ready = md_drain && md_occ < 2;
    acc   = rv && ready;
    last  = acc && md_idx == DEPTH-1;
    pop   = md_occ > 0 && mr;
    if (acc) begin
      q.push_back('{d, md_idx == 0, md_idx == DEPTH-1});
      seq++;
    end
    md_occ  = md_occ + int'(acc) - int'(pop);
    md_done = last;
    md_ovr  = md_drain && br && !last;
    if (last) md_fcnt = (md_fcnt + 1) % 65536;
    if (!md_drain) begin
      if (br && en) begin md_drain = 1; md_idx = 0; end
    end else if (last) begin
      md_idx = 0; md_drain = br && en;
    end else if (br) begin
      md_idx = 0;
    end else if (acc) begin
      md_idx++;
    end
    @(posedge clk); #1;
  endtask

  // Monitor: the head on the output must match the oldest expected sample.
  always @(negedge clk) begin
    if (m_valid_o) begin
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_output: got data %0h with no sample expected", m_data_o);
      end else begin
        chk("m_data", m_data_o, q[0].d);
        chk("m_sop", m_sop_o, q[0].s);
        chk("m_eop", m_eop_o, q[0].e);
        if (m_ready_i) void'(q.pop_front());
      end
    end
  end

  bit mrp[4] = '{1, 0, 0, 1};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_ready", rd_ready_o, 0);
    chk("rst_m_valid", m_valid_o, 0);
    chk("rst_m_data", m_data_o, 0);
    chk("rst_fcnt", frame_count_o, 0);
    chk("rst_busy", busy_o, 0);
    rst_ni = 1'b1;
    repeat (3) cyc(0, 1, 0, 1, seq);

    // Basic frame at full throughput.
    seq = '0;
    cyc(1, 1, 0, 1, seq);
    repeat (12) cyc(0, 1, 1, 1, seq);

    // Downstream backpressure pattern.
    cyc(1, 1, 0, 1, seq);
    for (int i = 0; i < 40; i++) cyc(0, 1, 1, mrp[i % 4], seq);

    // Overrun after three samples.
    cyc(1, 1, 0, 1, seq);
    for (int n = 0; n < 50 && md_idx != 3; n++) cyc(0, 1, 1, 1, seq);
    cyc(1, 1, 0, 1, seq);
    repeat (14) cyc(0, 1, 1, 1, seq);

    // Ready pulse coinciding with the last accept: back-to-back frames.
    cyc(1, 1, 0, 1, seq);
    for (int n = 0; n < 50 && !(md_drain && md_idx == DEPTH-1 && md_occ < 2); n++)
      cyc(0, 1, 1, 1, seq);
    cyc(1, 1, 1, 1, seq);
    repeat (12) cyc(0, 1, 1, 1, seq);

    // Disabled pulses are ignored; disabling mid-frame lets the frame finish.
    repeat (5) begin cyc(1, 0, 1, 1, seq); cyc(0, 0, 1, 1, seq); end
    cyc(1, 1, 0, 1, seq);
    repeat (3) cyc(0, 1, 1, 1, seq);
    repeat (15) cyc(0, 0, 1, 1, seq);

    // Asynchronous reset with two samples held in the FIFO.
    cyc(1, 1, 0, 1, seq);
    for (int n = 0; n < 10 && md_occ != 2; n++) cyc(0, 1, 1, 0, seq);
    rd_valid_i = 1'b0; buffer_ready_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_m_valid", m_valid_o, 0);
    chk("arst_m_data", m_data_o, 0);
    chk("arst_sop", m_sop_o, 0);
    chk("arst_eop", m_eop_o, 0);
    chk("arst_rd_ready", rd_ready_o, 0);
    chk("arst_done", frame_done_o, 0);
    chk("arst_ovr", overrun_o, 0);
    chk("arst_fcnt", frame_count_o, 0);
    chk("arst_busy", busy_o, 0);
    q.delete();
    md_drain = 0; md_idx = 0; md_occ = 0; md_fcnt = 0; md_done = 0; md_ovr = 0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    repeat (3) cyc(0, 1, 0, 1, seq);
    cyc(1, 1, 0, 1, seq);
    repeat (12) cyc(0, 1, 1, 1, seq);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 15) != 0,
          $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, WIDTH'($urandom));

    repeat (20) cyc(0, 1, 0, 1, seq);
    chk("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
